// File: rtl/vx_commit_arb_pkg.sv
// Shared commit-path types: the per-instruction commit payload and helpers
// used by the commit arbiter and its round-robin sub-arbiter.
package vx_commit_arb_pkg;

  localparam int NUM_THREADS = 4;
  localparam int NW_BITS     = 2;
  localparam int XLEN        = 32;
  localparam int RD_BITS     = 5;

  // Payload carried from an execution unit to writeback / scoreboard release.
  // eop sits in the LSB so "last micro-op of the instruction" is easy to spot.
  typedef struct packed {
    logic [NW_BITS-1:0]          wid;
    logic [NUM_THREADS-1:0]      tmask;
    logic                        wb;
    logic [RD_BITS-1:0]          rd;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic                        eop;
  } commit_data_t;

  localparam int COMMIT_DATA_W = $bits(commit_data_t);

  // Round-robin successor of a granted index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/vx_commit_arb_if.sv
// Commit arbiter bus: NUM_REQS unit-side commit inputs plus the merged output.
//
// Handshake: every channel uses valid/ready. A beat transfers on a rising clk
// edge where valid & ready are both 1. A source holding valid must keep its
// data stable until that transfer; ready may depend on valid, valid may not
// depend on ready.
interface vx_commit_arb_if #(
  parameter int NUM_REQS = 4
);
  import vx_commit_arb_pkg::*;

  localparam int GW = $clog2(NUM_REQS);

  logic [NUM_REQS-1:0]                in_valid;
  logic [NUM_REQS-1:0]                in_ready;
  commit_data_t [NUM_REQS-1:0]        in_data;
  logic                               out_valid;
  logic                               out_ready;
  commit_data_t                       out_data;
  logic [GW-1:0]                      out_grant;

  // master: execution units + writeback side; slave: the arbiter
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_grant
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_grant
  );

endinterface

// File: rtl/vx_commit_rr_arb.sv
// Combinational round-robin arbiter: searches requests starting at rr_ptr
// and reports the first hit as a one-hot grant (gated by enable) and as a
// binary index (always reported so the caller can advance its pointer).
module vx_commit_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  requests,
  input  logic [IW-1:0] rr_ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_index,
  output logic          grant_valid
);

  // first asserted request at or after rr_ptr, wrapping around
  always_comb begin
    int          sum;
    logic [IW-1:0] idx;
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    sum         = 0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = IW'(sum);
      if (!grant_valid && requests[idx]) begin
        grant_valid = 1'b1;
        grant_index = idx;
      end
    end
    if (enable && grant_valid) grant[grant_index] = 1'b1;
  end

endmodule

// File: rtl/vx_commit_arb.sv
// Per-issue-slot commit arbiter: round-robin merge of the execution-unit
// commit streams into a 2-entry registered buffer, plus a counter of
// retired (eop) commits delivered downstream.
module vx_commit_arb
  import vx_commit_arb_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_commit_arb_if.slave       bus,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  localparam int GW = $clog2(NUM_REQS);

  typedef struct packed {
    commit_data_t  data;
    logic [GW-1:0] src;
  } entry_t;

  entry_t              fifo_mem [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          count;
  logic [GW-1:0]       rr_ptr;
  entry_t              head;

  logic                full;
  logic                pop;
  logic                push;
  logic                can_accept;
  logic [NUM_REQS-1:0] grant;
  logic [GW-1:0]       grant_index;
  logic                grant_valid;

  assign full       = (count == 2'd2);
  assign pop        = bus.out_valid && bus.out_ready;
  // a pop this cycle frees the slot the push will land in
  assign can_accept = !full || pop;

  vx_commit_rr_arb #(.N(NUM_REQS)) u_rr_arb (
    .requests    (bus.in_valid),
    .rr_ptr      (rr_ptr),
    .enable      (can_accept),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  assign bus.in_ready = grant;
  assign push         = grant_valid && can_accept;

  // tail slot: with two slots the tail is the head flipped by count parity;
  // at count 2 this is the head slot, which is being popped in the same cycle
  assign wr_ptr        = rd_ptr ^ count[0];
  assign head          = fifo_mem[rd_ptr];
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = head.data;
  assign bus.out_grant = head.src;

  // buffer storage: capture the winner's payload and source index on push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else if (push) begin
      fifo_mem[wr_ptr] <= '{data: bus.in_data[grant_index], src: grant_index};
    end
  end

  // buffer occupancy and read pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
    end else begin
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // round-robin pointer moves past the winner only when it is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= GW'(rr_next(int'(grant_index), NUM_REQS));
    end
  end

  // retired-instruction counter: one per delivered eop commit, wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
    end else if (pop && head.data.eop) begin
      retired_cnt <= retired_cnt + 1'b1;
    end
  end

  // at most one accept per cycle, no pop from empty, no overfill
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.in_ready));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (reset)
    pop |-> (count != 2'd0));
  a_no_overfill : assert property (@(posedge clk) disable iff (reset)
    (push && full) |-> pop);

endmodule
